// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
package corePckg;

   localparam int cXLEN = 32;

   // RV32I load/store funct3 encodings
   localparam logic [2:0] cF3Byte  = 3'b000;
   localparam logic [2:0] cF3Half  = 3'b001;
   localparam logic [2:0] cF3Word  = 3'b010;
   localparam logic [2:0] cF3ByteU = 3'b100;
   localparam logic [2:0] cF3HalfU = 3'b101;

   typedef struct packed {
      logic             write;
      logic [2:0]       funct3;
      logic [cXLEN-1:0] addr;
      logic [cXLEN-1:0] wdata;
      logic [4:0]       rd;
   } tDmemReq;

   typedef struct packed {
      logic             we;
      logic [4:0]       rd;
      logic [cXLEN-1:0] data;
      logic             err;
   } tDmemRsp;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } tDmemState;

   // Unsupported funct3 or an access not aligned to its own size
   function automatic logic isIllegalReq(input logic       write,
                                         input logic [2:0] funct3,
                                         input logic [1:0] addrLo);
      logic bad;
      bad = 1'b0;
      if (write) begin
         if (funct3 > cF3Word) bad = 1'b1;
      end else begin
         if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) bad = 1'b1;
      end
      if (funct3[1:0] == 2'b01 && addrLo[0]) bad = 1'b1;
      if (funct3[1:0] == 2'b10 && addrLo != 2'b00) bad = 1'b1;
      return bad;
   endfunction

endpackage

// File: rtl/data_mem_responder_ram.sv
// Single-port word RAM with synchronous read and per-byte write enables.
module dmemRam #(
   parameter int cDepthWords = 1024
) (
   input  logic                           iClk,
   input  logic                           iEn,
   input  logic [3:0]                     iWe,
   input  logic [$clog2(cDepthWords)-1:0] iAddr,
   input  logic [31:0]                    iWData,
   output logic [31:0]                    oRData
);

   logic [31:0] mem_q [cDepthWords];
   logic [31:0] rdata_q;

   // Byte-lane writes and read-before-write word read on every enabled cycle
   always_ff @(posedge iClk) begin
      if (iEn) begin
         for (int b = 0; b < 4; b++) begin
            if (iWe[b]) mem_q[iAddr][8*b +: 8] <= iWData[8*b +: 8];
         end
         rdata_q <= mem_q[iAddr];
      end
   end

   assign oRData = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder: one request at a time, wait states, then RAM access.
module data_mem_responder
   import corePckg::*;
#(
   parameter int cDepthWords = 1024,
   parameter int cWaitStates = 1
) (
   input  logic             iClk,
   input  logic             iRst,
   input  logic             iReqValid,
   output logic             oReqReady,
   input  logic             iReqWrite,
   input  logic [2:0]       iReqFunct3,
   input  logic [cXLEN-1:0] iReqAddr,
   input  logic [cXLEN-1:0] iReqWData,
   input  logic [4:0]       iReqRd,
   output logic             oRspValid,
   output logic             oRspWe,
   output logic [4:0]       oRspRd,
   output logic [cXLEN-1:0] oRspData,
   output logic             oRspErr
);

   localparam int cIdxW = $clog2(cDepthWords);

   tDmemState       state_q, state_d;
   tDmemReq         req_q, req_d;
   logic [3:0]      cnt_q, cnt_d;
   logic            err_q, err_d;
   tDmemRsp         rsp;

   logic            ramEn;
   logic [3:0]      ramWe;
   logic [31:0]     ramWData;
   logic [31:0]     ramRData;
   logic            unusedAddrBits;

   // Store lane mask from size and low address bits
   function automatic logic [3:0] storeMask(input logic [2:0] f3, input logic [1:0] lo);
      case (f3)
         cF3Byte: return 4'b0001 << lo;
         cF3Half: return lo[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   // Replicate the low store bytes onto every lane so the mask picks the right one
   function automatic logic [31:0] storeData(input logic [2:0] f3, input logic [31:0] wd);
      case (f3)
         cF3Byte: return {4{wd[7:0]}};
         cF3Half: return {2{wd[15:0]}};
         default: return wd;
      endcase
   endfunction

   // Select the addressed byte/halfword and extend it to a register value
   function automatic logic [31:0] loadExtract(input logic [2:0] f3, input logic [1:0] lo,
                                               input logic [31:0] word);
      logic [31:0] sh;
      sh = word >> {lo, 3'b000};
      case (f3)
         cF3Byte:  return {{24{sh[7]}}, sh[7:0]};
         cF3ByteU: return {24'd0, sh[7:0]};
         cF3Half:  return {{16{sh[15]}}, sh[15:0]};
         cF3HalfU: return {16'd0, sh[15:0]};
         default:  return word;
      endcase
   endfunction

   // State register; request fields carry no reset
   always_ff @(posedge iClk) begin
      if (iRst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
      req_q <= req_d;
   end

   // Next-state logic: accept, count wait states, access, respond
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      req_d   = req_q;
      case (state_q)
         IDLE: begin
            if (iReqValid) begin
               req_d = '{write: iReqWrite, funct3: iReqFunct3, addr: iReqAddr,
                         wdata: iReqWData, rd: iReqRd};
               err_d = isIllegalReq(iReqWrite, iReqFunct3, iReqAddr[1:0]);
               if (err_d) begin
                  state_d = RESP;
               end else if (cWaitStates == 0) begin
                  state_d = ACCESS;
               end else begin
                  cnt_d   = 4'(cWaitStates);
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) state_d = ACCESS;
         end
         ACCESS: state_d = RESP;
         RESP: begin
            err_d   = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs: handshake, RAM port and the one-cycle response
   always_comb begin
      oReqReady = (state_q == IDLE);
      ramEn     = (state_q == ACCESS);
      ramWe     = 4'b0000;
      if (ramEn && req_q.write && !iRst) ramWe = storeMask(req_q.funct3, req_q.addr[1:0]);
      ramWData  = storeData(req_q.funct3, req_q.wdata);
      oRspValid = (state_q == RESP);
      rsp       = '0;
      if (oRspValid) begin
         rsp.err = err_q;
         if (!err_q && !req_q.write) begin
            rsp.data = loadExtract(req_q.funct3, req_q.addr[1:0], ramRData);
            rsp.rd   = req_q.rd;
            rsp.we   = (req_q.rd != 5'd0);
         end
      end
      oRspWe   = rsp.we;
      oRspRd   = rsp.rd;
      oRspData = rsp.data;
      oRspErr  = rsp.err;
   end

   // Upper address bits are don't-care: the RAM wraps
   assign unusedAddrBits = ^req_q.addr[cXLEN-1:cIdxW+2];

   dmemRam #(.cDepthWords(cDepthWords)) uRam (
      .iClk   (iClk),
      .iEn    (ramEn),
      .iWe    (ramWe),
      .iAddr  (req_q.addr[cIdxW+1:2]),
      .iWData (ramWData),
      .oRData (ramRData)
   );

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

- Data-memory responder for the core's load/store path.
- Accepts one load or store request at a time from the execute/write-back side over a valid/ready handshake.
- Performs the access on an internal word-organised RAM after a configurable number of wait states.
- Returns one response per request. For loads, the response is a register write (rd, data, write-enable) that feeds the register file's memory write port.

## Interface
Parameters:
- cDepthWords, 1024, RAM depth in 32-bit words; power of two.
- cWaitStates, 1, extra latency cycles before the access; range 0..15.

Ports:
- iClk  in  1  clock.
- iRst  in  1  reset: one clock, synchronous, active-high.
- iReqValid  in  1  request present.
- oReqReady  out  1  responder can accept a request.
- iReqWrite  in  1  1 = store, 0 = load.
- iReqFunct3  in  3  RV32I load/store funct3.
- iReqAddr  in  cXLEN  byte address.
- iReqWData  in  cXLEN  store data; only the low bytes are used.
- iReqRd  in  5  load destination register.
- oRspValid  out  1  one-cycle response pulse.
- oRspWe  out  1  register write enable.
- oRspRd  out  5  destination register.
- oRspData  out  cXLEN  load result.
- oRspErr  out  1  misaligned or illegal request.

## Operation
- States: IDLE, WAIT, ACCESS, RESP.
- IDLE:
  - oReqReady=1.
  - On iReqValid, latch every request field.
  - If the request is illegal, go to RESP. Otherwise load the wait counter with cWaitStates and go to WAIT, or go to ACCESS if cWaitStates=0.
- WAIT: decrement the counter each cycle; go to ACCESS when it reaches 1.
- ACCESS:
  - Word index = addr[log2(cDepthWords)+1:2]. Upper address bits are ignored, so addresses wrap modulo the RAM size.
  - Stores: the write commits at the end of this cycle under a byte mask.
  - Loads: synchronous read of the word.
  - Then go to RESP.
- RESP:
  - oRspValid=1 for exactly one cycle, then IDLE.
  - There is no response backpressure.
- Loads:
  - Extract the byte or halfword at addr[1:0].
  - LB and LH sign-extend; LBU and LHU zero-extend; LW takes the full word.
  - oRspWe=1 unless rd=0. oRspRd = latched rd.
- Stores:
  - SB uses byte lane addr[1:0]; SH uses lanes addr[1]*2 and +1; SW uses all four lanes.
  - Response has oRspWe=0 and oRspData=0.
- Illegal requests get no memory access and respond with oRspErr=1, oRspWe=0, oRspData=0:
  - load funct3 of 011, 110 or 111;
  - store funct3 above 010;
  - halfword with addr[0]=1;
  - word with addr[1:0]≠0.
- oRspErr=0 on every legal response.
- Outputs other than oReqReady are 0 whenever oRspValid=0.

## Timing
- Request accepted at edge t, when iReqValid&oReqReady are sampled high.
- Legal request: oRspValid is high in the cycle after edge t+1+cWaitStates, i.e. latency 2+cWaitStates cycles.
- Illegal request: response in the cycle after edge t (latency 1).
- oReqReady is low from the cycle after acceptance through RESP inclusive.
- Next acceptance is possible at the first IDLE cycle after RESP. Legal-request throughput is one request per 3+cWaitStates cycles.
- Reset:
  - Values after reset: state=IDLE, oReqReady=1, all other outputs 0, wait counter 0.
  - RAM contents are not reset.
- Reset mid-operation:
  - The in-flight request is dropped and no response is issued.
  - A store in WAIT does not commit.
  - A store in ACCESS commits only if reset is not asserted at that edge; reset has priority.
- iReqValid held high continuously: one request is accepted per IDLE cycle; the requester keeps its fields stable until it sees oReqReady.

## Structure
- In corePckg:
  - typedef tDmemReq (write, funct3, addr, wdata, rd);
  - typedef tDmemRsp (we, rd, data, err);
  - enum tDmemState;
  - funct3 constants cF3Byte, cF3Half, cF3Word, cF3ByteU, cF3HalfU.
- Sub-module dmemRam: single-port, synchronous read, 4-lane byte-write-enable RAM of cDepthWords×32.
- FSM, lane alignment and extension stay in data_mem_responder.

## Test plan
- cWaitStates=3: SW 0xDEADBEEF to 0x40 at t, then LW 0x40 rd=5.
  - Store response at t+5 with oRspWe=0.
  - Load returns 0xDEADBEEF, rd=5, oRspWe=1, 5 cycles after its accept.
- Preload 0x11223344 at 0x100. SB 0x55 to 0x101, then LW 0x100 returns 0x11225544.
- 0x80 at byte 0x200:
  - LB returns 0xFFFFFF80.
  - LBU returns 0x00000080.
  - LH 0x200 of 0x8001 returns 0xFFFF8001.
- Error responses, each one cycle after accept, with no RAM change:
  - LH at 0x3 gives oRspErr=1.
  - SW at 0x6 gives oRspErr=1.
  - Load funct3=011 gives oRspErr=1.
- Reset during WAIT of SW 0xCAFEF00D to 0x80:
  - No oRspValid.
  - oReqReady=1 the cycle after reset.
  - A later LW 0x80 returns the prior contents.
- LW rd=0 gives oRspValid=1 with oRspWe=0.
- Address wrap: cDepthWords=1024, SW to 0x1004, then LW 0x4 returns the stored value.
